// File: rtl/jk_sync_down_counter_pkg.sv
// Shared types and helpers for the JK-cell counter family.
// Latency: n/a (types and combinational helpers only).
// Backpressure: n/a.
package jk_cnt_pkg;

    localparam int CNT_W_DEFAULT = 4;

    // Source of the next counter value, chosen once per edge in the top.
    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_LOAD,
        SRC_DEC,
        SRC_RELOAD,
        SRC_WRAP
    } src_e;

    // Bit i of a binary down counter toggles when every lower bit is 0.
    // Bit 0 has no lower bits, so it always toggles.
    function automatic logic all_zero_below(input logic [63:0] vec, input int i);
        logic r;
        r = 1'b1;
        for (int j = 0; j < 64; j++) begin
            if ((j < i) && vec[j]) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/jk_sync_down_counter_if.sv
// Control/status bundle of the JK counter: driver side is master, counter is slave.
// Latency: n/a (wires only).
// Backpressure: none; up_dn exists only when JK_CNT_UPDN_EN is defined.
interface jk_sync_down_counter_if
    import jk_cnt_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
`ifdef JK_CNT_UPDN_EN
    logic             up_dn;
`endif
    logic             reload_en;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             tc;
    logic             underflow;

    modport master (
        output en, load, load_val,
`ifdef JK_CNT_UPDN_EN
        output up_dn,
`endif
        output reload_en,
        input  q, zero, tc, underflow
    );

    modport slave (
        input  en, load, load_val,
`ifdef JK_CNT_UPDN_EN
        input  up_dn,
`endif
        input  reload_en,
        output q, zero, tc, underflow
    );
endinterface

// File: rtl/jk_sync_down_counter_jk_ff_sync.sv
// Single JK flip-flop cell with synchronous active-high reset to RST_VAL.
// Latency: 1 clk from J/K to q.
// Backpressure: none; J=K=0 holds.
module jk_ff_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);
    logic r_q;

    // JK truth table: hold, clear, set, toggle; reset dominates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RST_VAL;
        end else begin
            case ({i_j, i_k})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/jk_sync_down_counter.sv
// Down counter from JK cells with load, auto-reload, tc cascade and underflow pulse.
// Latency: q/underflow update 1 clk after inputs; zero/tc are combinational.
// Backpressure: none; en=0 holds. Optional JK_CNT_UPDN_EN adds up_dn (up counting).
module jk_sync_down_counter
    import jk_cnt_pkg::*;
#(
    parameter int               WIDTH        = CNT_W_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b1}},
    parameter bit               STOP_AT_ZERO = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    jk_sync_down_counter_if.slave bus
);
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_zero;
    logic             w_term;
    logic             w_uf_evt;
    logic             w_stop_evt;
    src_e             w_src;
    logic [WIDTH-1:0] r_reload;
    logic             r_underflow;
    logic             r_stopped;

    assign w_zero = (w_q == '0);

    // Terminal value depends on direction: 0 counting down, all-ones counting up.
`ifdef JK_CNT_UPDN_EN
    assign w_term = bus.up_dn ? (&w_q) : w_zero;
`else
    assign w_term = w_zero;
`endif

    // Terminal + enabled + not loading is the underflow (overflow) event.
    // When parked at the terminal value, only the first such cycle pulses.
    assign w_stop_evt = STOP_AT_ZERO && !bus.reload_en;
    assign w_uf_evt   = bus.en && !bus.load && w_term && !(w_stop_evt && r_stopped);

    // Next-value source with priority load > en > hold (reset handled in cells).
    always_comb begin
        w_src = SRC_HOLD;
        if (bus.load) begin
            w_src = SRC_LOAD;
        end else if (bus.en) begin
            if (!w_term)            w_src = SRC_DEC;
            else if (bus.reload_en) w_src = SRC_RELOAD;
            else if (STOP_AT_ZERO)  w_src = SRC_HOLD;
            else                    w_src = SRC_WRAP;
        end
    end

    // Per-bit J/K drive: force for load/reload/wrap, toggle-chain for counting.
    always_comb begin
        w_j = '0;
        w_k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (w_src)
                SRC_LOAD: begin
                    w_j[i] = bus.load_val[i];
                    w_k[i] = ~bus.load_val[i];
                end
                SRC_RELOAD: begin
                    w_j[i] = r_reload[i];
                    w_k[i] = ~r_reload[i];
                end
                SRC_DEC: begin
`ifdef JK_CNT_UPDN_EN
                    w_j[i] = bus.up_dn ? all_zero_below(64'(~w_q), i)
                                       : all_zero_below(64'(w_q), i);
`else
                    w_j[i] = all_zero_below(64'(w_q), i);
`endif
                    w_k[i] = w_j[i];
                end
                SRC_WRAP: begin
`ifdef JK_CNT_UPDN_EN
                    w_j[i] = ~bus.up_dn;
                    w_k[i] = bus.up_dn;
`else
                    w_j[i] = 1'b1;
                    w_k[i] = 1'b0;
`endif
                end
                default: begin
                    w_j[i] = 1'b0;
                    w_k[i] = 1'b0;
                end
            endcase
        end
    end

    // One JK cell per count bit, each with its own reset value.
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_ff_sync #(
            .RST_VAL (RESET_VAL[g])
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .i_j   (w_j[g]),
            .i_k   (w_k[g]),
            .o_q   (w_q[g])
        );
    end

    // Reload register captures every parallel load.
    always_ff @(posedge clk) begin
        if (reset)          r_reload <= RESET_VAL;
        else if (bus.load)  r_reload <= bus.load_val;
    end

    // Underflow pulse and the parked-at-terminal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underflow <= 1'b0;
            r_stopped   <= 1'b0;
        end else if (bus.load) begin
            r_underflow <= 1'b0;
            r_stopped   <= 1'b0;
        end else begin
            r_underflow <= w_uf_evt;
            if (w_uf_evt && w_stop_evt) r_stopped <= 1'b1;
        end
    end

    assign bus.q         = w_q;
    assign bus.zero      = w_zero;
    assign bus.tc        = w_term && bus.en;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_jk_sync_down_counter.sv
module tb_jk_sync_down_counter;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    jk_sync_down_counter_if #(.WIDTH(4)) if_a ();
    jk_sync_down_counter_if #(.WIDTH(4)) if_s ();
    jk_sync_down_counter_if #(.WIDTH(4)) if_lo ();
    jk_sync_down_counter_if #(.WIDTH(4)) if_hi ();

    jk_sync_down_counter #(.WIDTH(4), .STOP_AT_ZERO(1'b0)) u_a  (.clk(clk), .reset(reset), .bus(if_a));
    jk_sync_down_counter #(.WIDTH(4), .STOP_AT_ZERO(1'b1)) u_s  (.clk(clk), .reset(reset), .bus(if_s));
    jk_sync_down_counter #(.WIDTH(4), .STOP_AT_ZERO(1'b0)) u_lo (.clk(clk), .reset(reset), .bus(if_lo));
    jk_sync_down_counter #(.WIDTH(4), .STOP_AT_ZERO(1'b0)) u_hi (.clk(clk), .reset(reset), .bus(if_hi));

    assign if_hi.en = if_lo.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        if_a.en = 1'b1;  if_a.load = 1'b0;  if_a.load_val = 4'd0;  if_a.reload_en = 1'b0;
        if_s.en = 1'b0;  if_s.load = 1'b0;  if_s.load_val = 4'd0;  if_s.reload_en = 1'b0;
        if_lo.en = 1'b0; if_lo.load = 1'b0; if_lo.load_val = 4'd0; if_lo.reload_en = 1'b0;
        if_hi.load = 1'b0; if_hi.load_val = 4'd0; if_hi.reload_en = 1'b0;
`ifdef JK_CNT_UPDN_EN
        if_a.up_dn = 1'b0; if_s.up_dn = 1'b0; if_lo.up_dn = 1'b0; if_hi.up_dn = 1'b0;
`endif

        // Reset held two edges with en=1.
        step();
        step();
        check("rst_q",    16'(if_a.q), 16'd15);
        check("rst_uf",   16'(if_a.underflow), 16'd0);
        check("rst_zero", 16'(if_a.zero), 16'd0);
        check("rst_s_q",  16'(if_s.q), 16'd15);

        // Count down 14..0.
        reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("dec_q%0d", k), 16'(if_a.q), 16'(15 - k));
            check($sformatf("dec_uf%0d", k), 16'(if_a.underflow), 16'd0);
        end
        check("z_zero", 16'(if_a.zero), 16'd1);
        check("z_tc",   16'(if_a.tc), 16'd1);

        // Wrap to all-ones with a single-cycle underflow.
        step();
        check("wrap_q",  16'(if_a.q), 16'd15);
        check("wrap_uf", 16'(if_a.underflow), 16'd1);
        check("wrap_tc", 16'(if_a.tc), 16'd0);
        step();
        check("wrap2_q",  16'(if_a.q), 16'd14);
        check("wrap2_uf", 16'(if_a.underflow), 16'd0);

        // Load 5 with en=1: load wins, no decrement.
        if_a.load = 1'b1; if_a.load_val = 4'd5;
        step();
        check("ld_q",  16'(if_a.q), 16'd5);
        check("ld_uf", 16'(if_a.underflow), 16'd0);

        // Auto-reload: 4,3,2,1,0,5 repeating.
        if_a.load = 1'b0; if_a.reload_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("rl_q%0d", k), 16'(if_a.q), 16'(5 - (k % 6)));
            check($sformatf("rl_uf%0d", k), 16'(if_a.underflow), 16'((k % 6) == 0));
        end

        // Hold with en=0, then load 0 with en=0: zero=1, tc=0.
        if_a.en = 1'b0; if_a.reload_en = 1'b0;
        step();
        check("hold_q", 16'(if_a.q), 16'd5);
        if_a.load = 1'b1; if_a.load_val = 4'd0;
        step();
        check("ld0_zero", 16'(if_a.zero), 16'd1);
        check("ld0_tc",   16'(if_a.tc), 16'd0);
        check("ld0_uf",   16'(if_a.underflow), 16'd0);

        // Reset wins over load mid-count.
        if_a.load_val = 4'd7;
        step();
        check("mid_q7", 16'(if_a.q), 16'd7);
        reset = 1'b1; if_a.load_val = 4'd9;
        step();
        check("mid_rst_q",  16'(if_a.q), 16'd15);
        check("mid_rst_uf", 16'(if_a.underflow), 16'd0);
        reset = 1'b0; if_a.load = 1'b0;

        // Stop-at-zero: load 2 -> 1, 0, 0, 0 with one underflow pulse.
        if_s.load = 1'b1; if_s.load_val = 4'd2;
        step();
        check("st_ld_q", 16'(if_s.q), 16'd2);
        if_s.load = 1'b0; if_s.en = 1'b1;
        step();
        check("st_q1",  16'(if_s.q), 16'd1);
        check("st_uf1", 16'(if_s.underflow), 16'd0);
        step();
        check("st_q2",  16'(if_s.q), 16'd0);
        check("st_uf2", 16'(if_s.underflow), 16'd0);
        step();
        check("st_q3",  16'(if_s.q), 16'd0);
        check("st_uf3", 16'(if_s.underflow), 16'd1);
        step();
        check("st_q4",  16'(if_s.q), 16'd0);
        check("st_uf4", 16'(if_s.underflow), 16'd0);
        step();
        check("st_uf5", 16'(if_s.underflow), 16'd0);
        if_s.load = 1'b1; if_s.load_val = 4'd3;
        step();
        check("st_rld_q", 16'(if_s.q), 16'd3);
        if_s.load = 1'b0;
        step();
        check("st_run_q", 16'(if_s.q), 16'd2);

        // Cascade: 0x00 -> 0xFF -> 0xFE.
        if_lo.load = 1'b1; if_hi.load = 1'b1;
        step();
        check("cas_0", {8'd0, if_hi.q, if_lo.q}, 16'h0000);
        if_lo.load = 1'b0; if_hi.load = 1'b0; if_lo.en = 1'b1;
        step();
        check("cas_1", {8'd0, if_hi.q, if_lo.q}, 16'h00FF);
        step();
        check("cas_2", {8'd0, if_hi.q, if_lo.q}, 16'h00FE);

`ifdef JK_CNT_UPDN_EN
        // Up mode overflow: 15 -> 0 with underflow pulse.
        if_a.load = 1'b1; if_a.load_val = 4'd15; if_a.en = 1'b1;
        step();
        if_a.load = 1'b0; if_a.up_dn = 1'b1;
        #1;
        check("up_tc", 16'(if_a.tc), 16'd1);
        step();
        check("up_q",  16'(if_a.q), 16'd0);
        check("up_uf", 16'(if_a.underflow), 16'd1);
        step();
        check("up_q1", 16'(if_a.q), 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
